// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a circular return-address stack.
// Picks the next PC from a 3-bit select and keeps CALL/RET addresses on the stack.
module pc_sequencer #(
  parameter int unsigned WIDTH                = 32,
  parameter int unsigned RAS_DEPTH            = 8,
  parameter int unsigned INC                  = 1,
  parameter logic [WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                               Clock,
  input  logic                               Reset_n,
  input  logic                               PC_enable,
  input  logic [2:0]                         PC_select,
  input  logic                               Cond,
  input  logic [WIDTH-1:0]                   BranchOff,
  input  logic [WIDTH-1:0]                   Target,
  input  logic [WIDTH-1:0]                   RA,
  input  logic                               RAS_clear,
  output logic [WIDTH-1:0]                   PC,
  output logic [WIDTH-1:0]                   PC_temp,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     RAS_count,
  output logic                               RAS_overflow,
  output logic                               RAS_underflow
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  typedef enum logic [2:0] {
    SEL_SEQ   = 3'b000,
    SEL_BREL  = 3'b001,
    SEL_JABS  = 3'b010,
    SEL_JREG  = 3'b011,
    SEL_CALL  = 3'b100,
    SEL_RET   = 3'b101,
    SEL_BCOND = 3'b110,
    SEL_HOLD  = 3'b111
  } sel_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_temp_q, pc_temp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] pc_inc, pc_rel;
  logic [PTR_W-1:0] top_next, top_prev;
  logic             push;
  sel_e             sel;

  assign sel      = sel_e'(PC_select);
  assign pc_inc   = pc_q + INC_W;
  assign pc_rel   = pc_q + BranchOff;
  // top_q is the next free slot; when full it is also the oldest entry.
  assign top_next = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + 1'b1;
  assign top_prev = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - 1'b1;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    pc_d      = pc_q;
    pc_temp_d = pc_q;
    cnt_d     = cnt_q;
    top_d     = top_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    push      = 1'b0;
    if (PC_enable) begin
      case (sel)
        SEL_SEQ:   pc_d = pc_inc;
        SEL_BREL:  pc_d = pc_rel;
        SEL_JABS:  pc_d = Target;
        SEL_JREG:  pc_d = RA;
        SEL_CALL: begin
          pc_d = Target;
          if (!RAS_clear) begin
            push  = 1'b1;
            top_d = top_next;
            if (cnt_q == CNT_W'(RAS_DEPTH)) ovf_d = 1'b1;
            else                            cnt_d = cnt_q + 1'b1;
          end
        end
        SEL_RET: begin
          if (!RAS_clear && cnt_q != '0) begin
            pc_d  = ras_q[top_prev];
            top_d = top_prev;
            cnt_d = cnt_q - 1'b1;
          end else begin
            pc_d  = RA;
            unf_d = !RAS_clear;
          end
        end
        SEL_BCOND: pc_d = Cond ? pc_rel : pc_inc;
        SEL_HOLD:  pc_d = pc_q;
        default:   pc_d = pc_q;
      endcase
      if (RAS_clear) cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q      <= RESET_PC;
      pc_temp_q <= RESET_PC;
      cnt_q     <= '0;
      top_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pc_temp_q <= pc_temp_d;
      cnt_q     <= cnt_d;
      top_q     <= top_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // NOTE: stack storage is not reset; entries are unreachable while cnt_q is zero.
  always_ff @(posedge Clock) begin
    if (push) ras_q[top_q] <= pc_inc;
  end

  assign PC            = pc_q;
  assign PC_temp       = pc_temp_q;
  assign RAS_count     = cnt_q;
  assign RAS_overflow  = ovf_q;
  assign RAS_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and random stimulus for pc_sequencer against a queue-based return-stack model.
module tb_pc_sequencer;

  localparam int DEPTH = 8;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        PC_enable;
  logic [2:0]  PC_select;
  logic        Cond;
  logic [31:0] BranchOff;
  logic [31:0] Target;
  logic [31:0] RA;
  logic        RAS_clear;
  logic [31:0] PC;
  logic [31:0] PC_temp;
  logic [3:0]  RAS_count;
  logic        RAS_overflow;
  logic        RAS_underflow;

  int checks = 0;
  int errors = 0;

  // Reference state: current PC and the return stack as a plain queue.
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];

  pc_sequencer #(.WIDTH(32), .RAS_DEPTH(DEPTH), .INC(1), .RESET_PC(32'h0)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .PC_enable(PC_enable), .PC_select(PC_select),
    .Cond(Cond), .BranchOff(BranchOff), .Target(Target), .RA(RA), .RAS_clear(RAS_clear),
    .PC(PC), .PC_temp(PC_temp), .RAS_count(RAS_count),
    .RAS_overflow(RAS_overflow), .RAS_underflow(RAS_underflow)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic [2:0] sel, input logic cnd,
                      input logic [31:0] off, input logic [31:0] tgt,
                      input logic [31:0] ra, input logic clr, input string tag);
    logic [31:0] e_temp;
    logic        e_ovf, e_unf;
    @(negedge Clock);
    PC_enable = en; PC_select = sel; Cond = cnd;
    BranchOff = off; Target = tgt; RA = ra; RAS_clear = clr;
    e_temp = m_pc;
    e_ovf  = 1'b0;
    e_unf  = 1'b0;
    if (en) begin
      case (sel)
        3'd0: m_pc = m_pc + 32'd1;
        3'd1: m_pc = m_pc + off;
        3'd2: m_pc = tgt;
        3'd3: m_pc = ra;
        3'd4: begin
          if (!clr) begin
            m_stack.push_back(m_pc + 32'd1);
            if (m_stack.size() > DEPTH) begin
              void'(m_stack.pop_front());
              e_ovf = 1'b1;
            end
          end
          m_pc = tgt;
        end
        3'd5: begin
          if (!clr && m_stack.size() > 0) m_pc = m_stack.pop_back();
          else begin
            m_pc  = ra;
            e_unf = !clr;
          end
        end
        3'd6: m_pc = cnd ? m_pc + off : m_pc + 32'd1;
        default: ;
      endcase
      if (clr) m_stack.delete();
    end
    @(posedge Clock);
    #1;
    check({tag, ".pc"}, PC, m_pc);
    check({tag, ".pc_temp"}, PC_temp, e_temp);
    check({tag, ".count"}, {28'd0, RAS_count}, 32'(m_stack.size()));
    check({tag, ".ovf"}, {31'd0, RAS_overflow}, {31'd0, e_ovf});
    check({tag, ".unf"}, {31'd0, RAS_underflow}, {31'd0, e_unf});
  endtask

  initial begin
    Reset_n = 1'b0; PC_enable = 1'b0; PC_select = 3'd0; Cond = 1'b0;
    BranchOff = '0; Target = '0; RA = '0; RAS_clear = 1'b0;
    m_pc = 32'h0;
    m_stack.delete();
    #1;
    check("reset.pc", PC, 32'h0);
    check("reset.pc_temp", PC_temp, 32'h0);
    check("reset.count", {28'd0, RAS_count}, 32'd0);
    check("reset.flags", {30'd0, RAS_overflow, RAS_underflow}, 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // Sequential run from reset: PC 1..4, PC_temp lagging.
    for (int i = 0; i < 4; i++) step(1, 3'd0, 0, 0, 0, 0, 0, "seq");

    // Negative relative branch and wrap-around.
    step(1, 3'd2, 0, 0, 32'h10, 0, 0, "jabs10");
    step(1, 3'd1, 0, 32'hFFFF_FFFC, 0, 0, 0, "brel_neg");
    check("brel_neg.value", PC, 32'h0C);
    step(1, 3'd2, 0, 0, 32'hFFFF_FFFF, 0, 0, "jabs_max");
    step(1, 3'd0, 0, 0, 0, 0, 0, "seq_wrap");
    check("seq_wrap.value", PC, 32'h0);

    // CALL / SEQ / SEQ / RET round trip.
    step(1, 3'd2, 0, 0, 32'h20, 0, 1, "jabs20_clr");
    step(1, 3'd4, 0, 0, 32'h100, 0, 0, "call100");
    step(1, 3'd0, 0, 0, 0, 0, 0, "call_seq1");
    step(1, 3'd0, 0, 0, 0, 0, 0, "call_seq2");
    step(1, 3'd5, 0, 0, 0, 32'hDEAD, 0, "ret21");
    check("ret21.value", PC, 32'h21);

    // Nine calls overflow the 8-deep stack, nine returns drain and underflow.
    for (int i = 0; i < 9; i++) step(1, 3'd4, 0, 0, 32'h1000 + 32'(i) * 32'h10, 0, 0, "call_ovf");
    check("call_ovf.full", {28'd0, RAS_count}, 32'd8);
    for (int i = 0; i < 9; i++) step(1, 3'd5, 0, 0, 0, 32'hABCD_0000, 0, "ret_drain");
    check("ret_drain.ra", PC, 32'hABCD_0000);

    // BCOND both ways, JREG, HOLD, and a RET under clear.
    step(1, 3'd6, 1, 32'h40, 0, 0, 0, "bcond_t");
    step(1, 3'd6, 0, 32'h40, 0, 0, 0, "bcond_f");
    step(1, 3'd3, 0, 0, 0, 32'h5555, 0, "jreg");
    step(1, 3'd7, 0, 0, 0, 0, 0, "hold");
    step(1, 3'd4, 0, 0, 32'h300, 0, 0, "call_pre_clr");
    step(1, 3'd5, 0, 0, 0, 32'h777, 1, "ret_clr");

    // Disabled CALL holds PC and count, PC_temp still loads.
    step(1, 3'd4, 0, 0, 32'h400, 0, 0, "call_a");
    step(0, 3'd4, 0, 0, 32'h500, 0, 0, "call_dis");
    step(1, 3'd4, 0, 0, 32'h600, 0, 0, "call_b");
    step(1, 3'd4, 0, 0, 32'h700, 0, 0, "call_c");
    check("pre_reset.count", {28'd0, RAS_count}, 32'd3);

    // Asynchronous reset between edges with three stacked entries.
    #1 Reset_n = 1'b0;
    #1;
    check("async_rst.pc", PC, 32'h0);
    check("async_rst.pc_temp", PC_temp, 32'h0);
    check("async_rst.count", {28'd0, RAS_count}, 32'd0);
    Reset_n = 1'b1;
    m_pc = 32'h0;
    m_stack.delete();
    step(1, 3'd0, 0, 0, 0, 0, 0, "post_rst_seq");
    step(1, 3'd5, 0, 0, 0, 32'h999, 0, "post_rst_ret");

    // Random mix, weighted toward stack traffic.
    for (int i = 0; i < 1500; i++) begin
      logic        en, cnd, clr;
      logic [2:0]  sel;
      logic [31:0] off;
      en  = ($urandom_range(0, 9) != 0);
      sel = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(4, 5)) : 3'($urandom);
      cnd = 1'($urandom);
      clr = en && ($urandom_range(0, 19) == 0);
      off = ($urandom_range(0, 1) == 0) ? 32'($signed(8'($urandom))) : $urandom;
      step(en, sel, cnd, off, $urandom, $urandom, clr, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
